// File: rtl/tt_sel_driver_if.sv
// Command, status and controller-select signals of tt_sel_driver.
// The master modport is the command issuer; the slave modport is the driver itself.
interface tt_sel_driver_if #(
    parameter int unsigned ADDR_W = 10
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_ena;
    logic              cmd_force;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_valid;
    logic              ctrl_sel_rst_n;
    logic              ctrl_sel_inc;
    logic              ctrl_ena;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_ena,
        output cmd_force,
        input  cmd_ready,
        input  done,
        input  busy,
        input  cur_addr,
        input  cur_valid,
        input  ctrl_sel_rst_n,
        input  ctrl_sel_inc,
        input  ctrl_ena
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_ena,
        input  cmd_force,
        output cmd_ready,
        output done,
        output busy,
        output cur_addr,
        output cur_valid,
        output ctrl_sel_rst_n,
        output ctrl_sel_inc,
        output ctrl_ena
    );

endinterface

// File: rtl/tt_sel_driver.sv
// Initiator of the tt_ctrl design-select protocol: optional select reset, a train of
// increment pulses, then the final enable. Skips the reset when incrementing reaches the target.
module tt_sel_driver #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned GUARD      = 2,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned PULSE_W    = 2
) (
    input logic           clk,
    input logic           rst,
    tt_sel_driver_if.slave bus
);

    localparam int unsigned TMax0 = (GUARD > RST_CYCLES) ? GUARD : RST_CYCLES;
    localparam int unsigned TMax  = (TMax0 > PULSE_W) ? TMax0 : PULSE_W;
    localparam int unsigned TW    = (TMax > 1) ? $clog2(TMax) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StDis,
        StRst,
        StGap,
        StIncHi,
        StIncLo,
        StFin
    } state_e;

    state_e r_state, w_state_d;

    logic [TW-1:0]     r_tmr, w_tmr_d;
    logic [ADDR_W-1:0] r_n, w_n_d;
    logic [ADDR_W-1:0] r_addr, w_addr_d;
    logic              r_ena, w_ena_d;
    logic              r_full, w_full_d;

    logic              r_cmd_ready, w_cmd_ready_d;
    logic              r_busy, w_busy_d;
    logic              r_done, w_done_d;
    logic [ADDR_W-1:0] r_cur_addr, w_cur_addr_d;
    logic              r_cur_valid, w_cur_valid_d;
    logic              r_rst_n, w_rst_n_d;
    logic              r_inc, w_inc_d;
    logic              r_ctrl_ena, w_ctrl_ena_d;

    logic              w_full_now;
    logic [ADDR_W-1:0] w_n_now;

    // A downward move cannot be reached by incrementing, so it forces a full reset.
    assign w_full_now = bus.cmd_force | ~r_cur_valid | (bus.cmd_addr < r_cur_addr);
    assign w_n_now    = w_full_now ? bus.cmd_addr : bus.cmd_addr - r_cur_addr;

    always_comb begin
        w_state_d = r_state;
        w_tmr_d   = r_tmr;
        w_n_d     = r_n;
        w_addr_d  = r_addr;
        w_ena_d   = r_ena;
        w_full_d  = r_full;

        unique case (r_state)
            StIdle: begin
                if (bus.cmd_valid) begin
                    w_addr_d  = bus.cmd_addr;
                    w_ena_d   = bus.cmd_ena;
                    w_full_d  = w_full_now;
                    w_n_d     = w_n_now;
                    w_tmr_d   = TW'(GUARD - 1);
                    w_state_d = StDis;
                end
            end
            StDis: begin
                if (r_tmr == '0) begin
                    if (r_full) begin
                        w_tmr_d   = TW'(RST_CYCLES - 1);
                        w_state_d = StRst;
                    end else if (r_n != '0) begin
                        w_tmr_d   = TW'(PULSE_W - 1);
                        w_state_d = StIncHi;
                    end else begin
                        w_state_d = StFin;
                    end
                end else begin
                    w_tmr_d = r_tmr - 1'b1;
                end
            end
            StRst: begin
                if (r_tmr == '0) begin
                    w_tmr_d   = TW'(PULSE_W - 1);
                    w_state_d = StGap;
                end else begin
                    w_tmr_d = r_tmr - 1'b1;
                end
            end
            StGap: begin
                if (r_tmr == '0) begin
                    w_tmr_d   = TW'(PULSE_W - 1);
                    w_state_d = (r_n != '0) ? StIncHi : StFin;
                end else begin
                    w_tmr_d = r_tmr - 1'b1;
                end
            end
            StIncHi: begin
                if (r_tmr == '0) begin
                    w_tmr_d   = TW'(PULSE_W - 1);
                    w_state_d = StIncLo;
                end else begin
                    w_tmr_d = r_tmr - 1'b1;
                end
            end
            StIncLo: begin
                if (r_tmr == '0) begin
                    w_n_d     = r_n - 1'b1;
                    w_tmr_d   = TW'(PULSE_W - 1);
                    w_state_d = (w_n_d != '0) ? StIncHi : StFin;
                end else begin
                    w_tmr_d = r_tmr - 1'b1;
                end
            end
            StFin: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear in the cycle that state is held.
    always_comb begin
        w_cmd_ready_d = (w_state_d == StIdle);
        w_busy_d      = (w_state_d != StIdle);
        w_done_d      = (w_state_d == StFin);
        w_rst_n_d     = r_rst_n;
        w_inc_d       = 1'b0;
        w_ctrl_ena_d  = r_ctrl_ena;
        w_cur_valid_d = r_cur_valid;
        w_cur_addr_d  = r_cur_addr;

        unique case (w_state_d)
            StIdle: begin
            end
            StRst: begin
                w_rst_n_d     = 1'b0;
                w_cur_valid_d = 1'b0;
                w_ctrl_ena_d  = 1'b0;
            end
            StGap: begin
                w_rst_n_d    = 1'b1;
                w_ctrl_ena_d = 1'b0;
            end
            StIncHi: begin
                w_inc_d      = 1'b1;
                w_ctrl_ena_d = 1'b0;
            end
            StFin: begin
                w_ctrl_ena_d  = r_ena;
                w_cur_valid_d = 1'b1;
                w_cur_addr_d  = r_addr;
            end
            default: begin
                w_ctrl_ena_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_tmr       <= '0;
            r_n         <= '0;
            r_addr      <= '0;
            r_ena       <= 1'b0;
            r_full      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cur_addr  <= '0;
            r_cur_valid <= 1'b0;
            r_rst_n     <= 1'b0;
            r_inc       <= 1'b0;
            r_ctrl_ena  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_tmr       <= w_tmr_d;
            r_n         <= w_n_d;
            r_addr      <= w_addr_d;
            r_ena       <= w_ena_d;
            r_full      <= w_full_d;
            r_cmd_ready <= w_cmd_ready_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
            r_cur_addr  <= w_cur_addr_d;
            r_cur_valid <= w_cur_valid_d;
            r_rst_n     <= w_rst_n_d;
            r_inc       <= w_inc_d;
            r_ctrl_ena  <= w_ctrl_ena_d;
        end
    end

    assign bus.cmd_ready      = r_cmd_ready;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.cur_addr       = r_cur_addr;
    assign bus.cur_valid      = r_cur_valid;
    assign bus.ctrl_sel_rst_n = r_rst_n;
    assign bus.ctrl_sel_inc   = r_inc;
    assign bus.ctrl_ena       = r_ctrl_ena;

endmodule

// File: tb/tb_tt_sel_driver.sv
// Directed bench for tt_sel_driver: per-cycle waveform capture of each select sequence,
// compared against hand-derived cycle masks.
module tb_tt_sel_driver;

    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tt_sel_driver_if #(.ADDR_W(AW)) bus ();

    tt_sel_driver #(
        .ADDR_W    (AW),
        .GUARD     (2),
        .RST_CYCLES(4),
        .PULSE_W   (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] w_rstn, w_inc, w_ena, w_done, w_rdy;
    int          rises;
    int          done_cyc;
    logic        viol;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Handshake in the current cycle (cycle 0); returns in cycle 1.
    task automatic accept(input logic [AW-1:0] a, input logic e, input logic f);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_ena   = e;
        bus.cmd_force = f;
        chk("ready_at_accept", {63'b0, bus.cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_force = 1'b0;
    endtask

    // Records cycles 1..ncyc; optionally pulses cmd_valid with address pa in cycles pv_lo..pv_hi.
    task automatic capture(input int ncyc, input int pv_lo, input int pv_hi,
                           input logic [AW-1:0] pa);
        logic prev_inc;
        w_rstn   = '0;
        w_inc    = '0;
        w_ena    = '0;
        w_done   = '0;
        w_rdy    = '0;
        rises    = 0;
        done_cyc = -1;
        viol     = 1'b0;
        prev_inc = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c >= pv_lo && c <= pv_hi) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_addr  = pa;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (c < 64) begin
                w_rstn[c[5:0]] = bus.ctrl_sel_rst_n;
                w_inc[c[5:0]]  = bus.ctrl_sel_inc;
                w_ena[c[5:0]]  = bus.ctrl_ena;
                w_done[c[5:0]] = bus.done;
                w_rdy[c[5:0]]  = bus.cmd_ready;
            end
            if (bus.ctrl_sel_inc && !prev_inc) rises++;
            prev_inc = bus.ctrl_sel_inc;
            if (bus.done && done_cyc < 0) done_cyc = c;
            if (bus.ctrl_sel_inc && (!bus.ctrl_sel_rst_n || bus.ctrl_ena)) viol = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_wave(input string t, input logic [63:0] er, input logic [63:0] ei,
                              input logic [63:0] ee, input logic [63:0] ey,
                              input int exp_done, input int exp_rises);
        chk({t, " rst_n"}, w_rstn, er);
        chk({t, " inc"}, w_inc, ei);
        chk({t, " ena"}, w_ena, ee);
        chk({t, " ready"}, w_rdy, ey);
        chk({t, " done_mask"}, w_done, (exp_done > 0) ? rng(exp_done, exp_done) : 64'd0);
        chk({t, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({t, " inc_rises"}, 64'(rises), 64'(exp_rises));
        chk({t, " inc_guard"}, {63'b0, viol}, 64'd0);
    endtask

    task automatic check_cur(input string t, input logic [AW-1:0] a, input logic v);
        chk({t, " cur_addr"}, {54'b0, bus.cur_addr}, {54'b0, a});
        chk({t, " cur_valid"}, {63'b0, bus.cur_valid}, {63'b0, v});
    endtask

    task automatic check_reset_vals(input string t);
        chk({t, " rst_n"}, {63'b0, bus.ctrl_sel_rst_n}, 64'd0);
        chk({t, " inc"}, {63'b0, bus.ctrl_sel_inc}, 64'd0);
        chk({t, " ena"}, {63'b0, bus.ctrl_ena}, 64'd0);
        chk({t, " done"}, {63'b0, bus.done}, 64'd0);
        chk({t, " ready"}, {63'b0, bus.cmd_ready}, 64'd1);
        chk({t, " busy"}, {63'b0, bus.busy}, 64'd0);
        check_cur(t, '0, 1'b0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_ena   = 1'b1;
        bus.cmd_force = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // Full sequence from unknown state to address 3
        accept(10'd3, 1'b1, 1'b0);
        capture(22, 0, -1, '0);
        check_wave("s1_addr3", rng(7, 22), rng(9, 10) | rng(13, 14) | rng(17, 18),
                   rng(21, 22), rng(22, 22), 21, 3);
        check_cur("s1", 10'd3, 1'b1);

        // Incremental 3 -> 5
        accept(10'd5, 1'b1, 1'b0);
        capture(12, 0, -1, '0);
        check_wave("s2_addr5", rng(1, 12), rng(3, 4) | rng(7, 8), rng(11, 12), rng(12, 12), 11, 2);
        check_cur("s2", 10'd5, 1'b1);

        // Downward 5 -> 1 needs a full reset
        accept(10'd1, 1'b1, 1'b0);
        capture(14, 0, -1, '0);
        check_wave("s3_addr1", rng(1, 2) | rng(7, 14), rng(9, 10), rng(13, 14), rng(14, 14), 13, 1);
        check_cur("s3", 10'd1, 1'b1);

        // Same address, N=0, ena=0
        accept(10'd1, 1'b0, 1'b0);
        capture(4, 0, -1, '0);
        check_wave("s4_same", rng(1, 4), 64'd0, 64'd0, rng(4, 4), 3, 0);
        check_cur("s4", 10'd1, 1'b1);

        // Same address with force
        accept(10'd1, 1'b0, 1'b1);
        capture(14, 0, -1, '0);
        check_wave("s5_force", rng(1, 2) | rng(7, 14), rng(9, 10), 64'd0, rng(14, 14), 13, 1);
        check_cur("s5", 10'd1, 1'b1);

        // cmd_valid with addr=7 while busy must be ignored
        accept(10'd3, 1'b1, 1'b0);
        capture(12, 3, 6, 10'd7);
        check_wave("s6_busy_cmd", rng(1, 12), rng(3, 4) | rng(7, 8), rng(11, 12), rng(12, 12), 11, 2);
        check_cur("s6", 10'd3, 1'b1);
        chk("s6 idle_after", {63'b0, bus.busy}, 64'd0);

        // rst in cycle 12 of a forced addr=3 sequence
        accept(10'd3, 1'b1, 1'b1);
        capture(11, 0, -1, '0);
        check_wave("s7_pre_rst", rng(1, 2) | rng(7, 11), rng(9, 10), 64'd0, 64'd0, -1, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("s7_mid_rst");

        // After mid-sequence reset the state is unknown: full sequence to 2
        accept(10'd2, 1'b1, 1'b0);
        capture(18, 0, -1, '0);
        check_wave("s8_addr2", rng(7, 18), rng(9, 10) | rng(13, 14), rng(17, 18), rng(18, 18), 17, 2);
        check_cur("s8", 10'd2, 1'b1);

        // Incremental 2 -> 1023 (max address): N=1021, done at 2+4*1021+1
        accept(10'd1023, 1'b1, 1'b0);
        capture(4088, 0, -1, '0);
        chk("s9_max done_cycle", 64'(done_cyc), 64'd4087);
        chk("s9_max inc_rises", 64'(rises), 64'd1021);
        chk("s9_max inc_guard", {63'b0, viol}, 64'd0);
        check_cur("s9", 10'd1023, 1'b1);
        chk("s9_max ready", {63'b0, bus.cmd_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
